fpu_ss_cluster_arbiter: RTL and testbench

Shares one fpu_ss instance among NB_CORES cores. Round-robin (or fixed-priority) arbitration of per-core issue requests onto a single issue port. Each accepted instruction gets an internal slot tag, which is used as the downstream id so that ids from different cores never collide. Out-of-order results are routed back to the owning core with the core's original id restored.

---
 rtl/fpu_ss_cluster_arbiter.sv | 122 ++++++++++++
 tb/tb_fpu_ss_cluster_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_cluster_arbiter.sv
// fpu_ss_cluster_arbiter: shares one fpu_ss between NB_CORES cores, retagging ids with slot numbers
module fpu_ss_cluster_arbiter #(
   parameter int NB_CORES = 8,
   parameter int ID_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ROUND_ROBIN = 1,
   localparam int SLOT_W = $clog2(MAX_OUTSTANDING)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NB_CORES-1:0]            core_issue_valid_i,
   output logic [NB_CORES-1:0]            core_issue_ready_o,
   input  logic [NB_CORES*DATA_WIDTH-1:0] core_issue_instr_i,
   input  logic [NB_CORES*ID_WIDTH-1:0]   core_issue_id_i,
   output logic                           core_issue_accept_o,
   output logic                           x_issue_valid_o,
   input  logic                           x_issue_ready_i,
   output logic [DATA_WIDTH-1:0]          x_issue_instr_o,
   output logic [SLOT_W-1:0]              x_issue_id_o,
   input  logic                           x_issue_accept_i,
   input  logic                           x_result_valid_i,
   output logic                           x_result_ready_o,
   input  logic [SLOT_W-1:0]              x_result_id_i,
   input  logic [DATA_WIDTH-1:0]          x_result_data_i,
   output logic [NB_CORES-1:0]            core_result_valid_o,
   input  logic [NB_CORES-1:0]            core_result_ready_i,
   output logic [DATA_WIDTH-1:0]          core_result_data_o,
   output logic [ID_WIDTH-1:0]            core_result_id_o,
   output logic [SLOT_W:0]                outstanding_cnt_o,
   output logic                           err_o
);
   localparam int CIDX_W = $clog2(NB_CORES);

   logic [MAX_OUTSTANDING-1:0] slot_vld;
   logic [CIDX_W-1:0]          slot_core [MAX_OUTSTANDING];
   logic [ID_WIDTH-1:0]        slot_oid [MAX_OUTSTANDING];
   logic [CIDX_W-1:0]          rr_ptr, lock_core, arb_core, cand, gnt, owner;
   logic [SLOT_W-1:0]          lock_slot, free_slot, gnt_slot;
   logic [ID_WIDTH-1:0]        gnt_id;
   logic                       lock, arb_found, has_free, issue_hs, hit, free;

   always_comb begin
      has_free = ~&slot_vld;
      free_slot = '0;
      for (int i = MAX_OUTSTANDING - 1; i >= 0; i--)
         if (!slot_vld[i]) free_slot = SLOT_W'(i);
   end

   // search starts at the rr pointer, or at core 0 for fixed priority
   always_comb begin
      arb_found = 1'b0;
      arb_core = '0;
      cand = '0;
      for (int i = 0; i < NB_CORES; i++) begin
         cand = CIDX_W'(((ROUND_ROBIN != 0 ? int'(rr_ptr) : 0) + i) % NB_CORES);
         if (!arb_found && core_issue_valid_i[cand]) begin
            arb_found = 1'b1;
            arb_core = cand;
         end
      end
   end

   assign gnt = lock ? lock_core : arb_core;
   assign gnt_slot = lock ? lock_slot : free_slot;
   assign x_issue_valid_o = lock | (arb_found & has_free);
   assign issue_hs = x_issue_valid_o & x_issue_ready_i;
   assign core_issue_ready_o = issue_hs ? NB_CORES'(1) << gnt : '0;
   assign core_issue_accept_o = issue_hs & x_issue_accept_i;
   assign x_issue_id_o = gnt_slot;

   always_comb begin
      x_issue_instr_o = '0;
      gnt_id = '0;
      for (int i = 0; i < NB_CORES; i++)
         if (gnt == CIDX_W'(i)) begin
            x_issue_instr_o = core_issue_instr_i[i*DATA_WIDTH +: DATA_WIDTH];
            gnt_id = core_issue_id_i[i*ID_WIDTH +: ID_WIDTH];
         end
   end

   // results addressed to a free slot are swallowed and flagged
   assign hit = slot_vld[x_result_id_i];
   assign owner = slot_core[x_result_id_i];
   assign core_result_valid_o = (x_result_valid_i & hit) ? NB_CORES'(1) << owner : '0;
   assign core_result_id_o = slot_oid[x_result_id_i];
   assign core_result_data_o = x_result_data_i;
   assign x_result_ready_o = hit ? core_result_ready_i[owner] : 1'b1;
   assign err_o = x_result_valid_i & ~hit;
   assign free = x_result_valid_i & hit & core_result_ready_i[owner];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         slot_vld <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            slot_core[i] <= '0;
            slot_oid[i] <= '0;
         end
         rr_ptr <= '0;
         lock <= 1'b0;
         lock_core <= '0;
         lock_slot <= '0;
         outstanding_cnt_o <= '0;
      end else begin
         if (free) slot_vld[x_result_id_i] <= 1'b0;
         if (core_issue_accept_o) begin
            slot_vld[gnt_slot] <= 1'b1;
            slot_core[gnt_slot] <= gnt;
            slot_oid[gnt_slot] <= gnt_id;
         end
         if (issue_hs) begin
            lock <= 1'b0;
            rr_ptr <= (gnt == CIDX_W'(NB_CORES - 1)) ? '0 : gnt + 1'b1;
         end else if (x_issue_valid_o) begin
            lock <= 1'b1;
            lock_core <= gnt;
            lock_slot <= gnt_slot;
         end
         outstanding_cnt_o <= outstanding_cnt_o + (SLOT_W+1)'(core_issue_accept_o) - (SLOT_W+1)'(free);
      end
   end
endmodule

// File: tb/tb_fpu_ss_cluster_arbiter.sv
// tb_fpu_ss_cluster_arbiter: directed bench with a per-issue scoreboard for result routing
module tb_fpu_ss_cluster_arbiter;
   typedef struct {
      int         slot;
      int         core;
      logic [3:0] oid;
   } ent_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   cv, cir, crv, crr, crid;
   logic [127:0] cinstr;
   logic [15:0]  cid;
   logic         cia, xiv, xir, xia, xrv, xrr, err;
   logic [31:0]  xinstr, xrdata, crdata;
   logic [1:0]   xid, xrid;
   logic [2:0]   cnt;
   ent_t         sb[$];
   int           total = 0;
   int           bad = 0;

   fpu_ss_cluster_arbiter #(
      .NB_CORES(4), .ID_WIDTH(4), .DATA_WIDTH(32), .MAX_OUTSTANDING(4), .ROUND_ROBIN(1)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .core_issue_valid_i(cv), .core_issue_ready_o(cir), .core_issue_instr_i(cinstr),
      .core_issue_id_i(cid), .core_issue_accept_o(cia),
      .x_issue_valid_o(xiv), .x_issue_ready_i(xir), .x_issue_instr_o(xinstr),
      .x_issue_id_o(xid), .x_issue_accept_i(xia),
      .x_result_valid_i(xrv), .x_result_ready_o(xrr), .x_result_id_i(xrid),
      .x_result_data_i(xrdata),
      .core_result_valid_o(crv), .core_result_ready_i(crr), .core_result_data_o(crdata),
      .core_result_id_o(crid), .outstanding_cnt_o(cnt), .err_o(err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] instr_of(input int c);
      return 32'hC0DE_0000 | c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      xrv = 1'b0;
      xir = 1'b0;
      xia = 1'b0;
   endtask

   task automatic iss(input int core, input int slot, input logic rdy, input logic acc);
      xir = rdy;
      xia = acc;
      #1;
      chk("iss_valid", 32'(xiv), 1);
      chk("iss_instr", xinstr, instr_of(core));
      chk("iss_slot", 32'(xid), slot);
      chk("iss_ready", 32'(cir), rdy ? 4'b1 << core : 4'b0);
      chk("iss_accept", 32'(cia), 32'(rdy & acc));
      if (rdy && acc) sb.push_back('{slot, core, cid[core*4 +: 4]});
   endtask

   task automatic ret(input int s);
      int k;
      k = -1;
      foreach (sb[j]) if (sb[j].slot == s) k = j;
      xrv = 1'b1;
      xrid = 2'(s);
      xrdata = $urandom;
      #1;
      total++;
      assert (k >= 0) else begin
         bad++;
         $error("FAIL sb_lookup observed=slot %0d expected=an outstanding entry", s);
      end
      if (k >= 0) begin
         chk("res_valid", 32'(crv), 4'b1 << sb[k].core);
         chk("res_id", 32'(crid), 32'(sb[k].oid));
         chk("res_data", crdata, xrdata);
         chk("res_ready", 32'(xrr), 1);
         chk("res_err", 32'(err), 0);
         sb.delete(k);
      end
   endtask

   initial begin
      rst = 1'b1;
      cv = '0; xir = 0; xia = 0; xrv = 0; xrid = '0; xrdata = '0; crr = 4'hF;
      cid = {4'd4, 4'd3, 4'd2, 4'd1};
      for (int c = 0; c < 4; c++) cinstr[c*32 +: 32] = instr_of(c);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cnt", 32'(cnt), 0);
      chk("rst_xiv", 32'(xiv), 0);
      chk("rst_xrr", 32'(xrr), 1);
      chk("rst_cir", 32'(cir), 0);
      chk("rst_crv", 32'(crv), 0);
      chk("rst_err", 32'(err), 0);
      rst = 1'b0;
      tick();
      // round-robin with immediate result return
      cv = 4'hF;
      for (int n = 0; n < 5; n++) begin
         if (n > 0) ret((n - 1) % 2);
         iss(n % 4, n % 2, 1, 1);
         if (n > 0) chk("rr_cnt", 32'(cnt), 1);
         tick();
      end
      cv = 4'h0;
      ret(0);
      chk("rr_idle", 32'(xiv), 0);
      tick();
      chk("rr_cnt_end", 32'(cnt), 0);
      // lock under backpressure: core 2 held while cores 0 and 1 request
      cv = 4'b0100;
      iss(2, 0, 0, 0);
      tick();
      cv = 4'b0111;
      iss(2, 0, 0, 0);
      tick();
      iss(2, 0, 0, 0);
      tick();
      iss(2, 0, 1, 1);
      tick();
      cv = 4'b0011;
      iss(0, 1, 1, 1);
      tick();
      cv = 4'h0;
      ret(0);
      tick();
      ret(1);
      tick();
      chk("lock_cnt_end", 32'(cnt), 0);
      // out-of-order routing with colliding core ids
      cid = {4'd5, 4'd3, 4'd5, 4'd1};
      cv = 4'b0010;
      iss(1, 0, 1, 1);
      tick();
      cv = 4'b1000;
      iss(3, 1, 1, 1);
      tick();
      cv = 4'h0;
      chk("ooo_cnt", 32'(cnt), 2);
      crr = 4'b0111;
      xrv = 1'b1;
      xrid = 2'd1;
      #1;
      chk("bp_xrr", 32'(xrr), 0);
      chk("bp_crv", 32'(crv), 4'b1000);
      tick();
      chk("bp_cnt", 32'(cnt), 2);
      crr = 4'hF;
      ret(1);
      tick();
      ret(0);
      tick();
      chk("ooo_cnt_end", 32'(cnt), 0);
      // fill the table, then free slot 2
      cv = 4'hF;
      for (int n = 0; n < 4; n++) begin
         iss(n, n, 1, 1);
         tick();
      end
      chk("full_cnt", 32'(cnt), 4);
      xir = 1'b1;
      #1;
      chk("full_xiv", 32'(xiv), 0);
      chk("full_cir", 32'(cir), 0);
      ret(2);
      chk("full_free_hidden", 32'(xiv), 0);
      tick();
      chk("full_cnt_freed", 32'(cnt), 3);
      iss(0, 2, 1, 1);
      tick();
      chk("full_cnt_again", 32'(cnt), 4);
      cv = 4'h0;
      ret(0);
      tick();
      ret(1);
      tick();
      ret(3);
      tick();
      ret(2);
      tick();
      chk("full_cnt_end", 32'(cnt), 0);
      // rejected issue consumes no slot
      cv = 4'b0010;
      iss(1, 0, 1, 0);
      tick();
      cv = 4'h0;
      chk("rej_cnt", 32'(cnt), 0);
      // result addressed to a free slot
      xrv = 1'b1;
      xrid = 2'd3;
      #1;
      chk("err_pulse", 32'(err), 1);
      chk("err_crv", 32'(crv), 0);
      chk("err_xrr", 32'(xrr), 1);
      tick();
      #1;
      chk("err_clear", 32'(err), 0);
      // asynchronous reset with three slots in flight
      cv = 4'hF;
      iss(2, 0, 1, 1);
      tick();
      iss(3, 1, 1, 1);
      tick();
      iss(0, 2, 1, 1);
      tick();
      cv = 4'h0;
      chk("ar_cnt", 32'(cnt), 3);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_cnt_now", 32'(cnt), 0);
      chk("ar_xrr", 32'(xrr), 1);
      sb.delete();
      #1;
      rst = 1'b0;
      cv = 4'hF;
      iss(0, 0, 1, 1);
      tick();
      cv = 4'h0;
      chk("ar_cnt_after", 32'(cnt), 1);
      ret(0);
      tick();
      xrv = 1'b1;
      xrid = 2'd1;
      #1;
      chk("ar_err", 32'(err), 1);
      chk("ar_err_crv", 32'(crv), 0);
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
